oven_heat_controller: RTL and testbench
=======================================

# oven_heat_controller

Upstream control stage for the oven heating model: captures a user setpoint and bake duration, runs the preheat/bake/done sequence, and drives the `heat` command and target temperature consumed by the heating stage. The heating stage's `oven_temp` feeds back into this block to close the thermostat loop. The block uses a hysteresis band during bake so `heat` does not toggle every cycle.

## Interface
- `MAX_TEMP`, 10'd500: setpoint clamp ceiling.
- `HYST`, 10'd4: hysteresis band width during BAKE.
- `clock`  in  1  system clock; all state updates on the rising edge.
- `reset`  in  1  synchronous, active-high reset.
- `start`  in  1  one-cycle pulse; begins a run from IDLE or DONE.
- `cancel`  in  1  one-cycle pulse; aborts any run and returns to IDLE.
- `sec_tick`  in  1  one-cycle pulse once per second from the timebase.
- `setpoint`  in  10  requested temperature; sampled on an accepted `start`.
- `bake_time`  in  8  bake duration in seconds; sampled on an accepted `start`.
- `oven_temp`  in  10  current oven temperature from the heating stage.
- `heat`  out  1  heating command to the heating stage (registered).
- `target_temp`  out  10  latched, clamped setpoint (registered).
- `remaining`  out  8  bake seconds left (registered).
- `state`  out  2  0=IDLE, 1=PREHEAT, 2=BAKE, 3=DONE.
- `preheated`  out  1  high while in BAKE.
- `done`  out  1  high while in DONE.

## Operation
- Reset: state=IDLE, heat=0, target_temp=0, remaining=0, preheated=0, done=0. Reset overrides all other inputs, including mid-run.
- Priority each cycle: reset > cancel > start > normal sequencing.
- IDLE: heat=0. When `start` is high, latch target_temp = min(setpoint, MAX_TEMP) and remaining = bake_time, then go to PREHEAT.
- PREHEAT: heat=1 while oven_temp < target_temp. When oven_temp >= target_temp, go to BAKE with heat=0. If target_temp is 0, enter BAKE on the next edge.
- BAKE:
  - Thermostat: heat<=1 if oven_temp < low, where low = target_temp − HYST, saturating at 0.
  - heat<=0 if oven_temp >= target_temp.
  - Otherwise heat holds its value.
- BAKE timer:
  - On `sec_tick`, remaining decrements.
  - A tick when remaining==1 sets remaining=0 and goes to DONE.
  - If remaining==0 on entry to BAKE, go to DONE on the next edge without waiting for a tick.
- DONE: heat=0, done=1. target_temp is held. `start` begins a new run (re-latch, go to PREHEAT).
- `start` in PREHEAT or BAKE is ignored.
- `cancel` in any state: go to IDLE, heat=0, remaining=0, target_temp held.
- `sec_tick` outside BAKE is ignored.
- Arithmetic: all comparisons are 10-bit unsigned. The clamp and the low-band subtraction must not wrap.

## Timing
- All outputs are registered. `heat` reflects the oven_temp and state sampled at the previous edge, so the loop has one cycle of latency.
- Accepted `start` at edge N: state=PREHEAT and target_temp is valid after edge N. Earliest heat=1 is after edge N+1.
- PREHEAT→BAKE: occurs at the first edge where sampled oven_temp >= target_temp. heat=0 in the same update.
- BAKE→DONE: occurs at the edge sampling the final tick. done=1 and heat=0 after that edge.
- Same-cycle `cancel` and `start`: cancel wins, state=IDLE.
- Same-cycle `sec_tick` and PREHEAT→BAKE transition: the tick is not counted.
- `state`, `preheated` and `done` are mutually consistent in every cycle.

## Test plan
- Reset mid-BAKE (setpoint 200, remaining 30) -> next cycle state=0, heat=0, target_temp=0, remaining=0, done=0.
- start with setpoint 300, bake_time 3; oven_temp ramps 0→300 -> PREHEAT heat=1 until oven_temp=300, then BAKE. Three ticks take remaining 3→2→1→0, then DONE, done=1, heat=0.
- BAKE, target 300, HYST 4:
  - oven_temp 297 after heat=0 -> heat stays 0.
  - oven_temp 295 -> heat=1.
  - oven_temp 298 -> heat stays 1.
  - oven_temp 300 -> heat=0.
- setpoint 1000 -> target_temp=500. setpoint 2, HYST 4 -> low band saturates at 0, no wrap: heat=0 at oven_temp 1.
- bake_time 0, setpoint 0 -> PREHEAT→BAKE→DONE on consecutive edges with heat never asserted.
- cancel and start pulsed together in BAKE -> IDLE. start during PREHEAT -> ignored, target_temp unchanged. start in DONE with setpoint 150 -> PREHEAT, target_temp=150.

Source files
------------

// File: rtl/oven_heat_controller.sv
// Oven heat controller: setpoint/bake capture and preheat/bake/done sequencing.
// Ports: clock, reset, start, cancel, sec_tick, setpoint, bake_time, oven_temp
//        -> heat, target_temp, remaining, state, preheated, done (all registered).
module oven_heat_controller #(
  parameter logic [9:0] MAX_TEMP = 10'd500,
  parameter logic [9:0] HYST     = 10'd4
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       start,
  input  logic       cancel,
  input  logic       sec_tick,
  input  logic [9:0] setpoint,
  input  logic [7:0] bake_time,
  input  logic [9:0] oven_temp,
  output logic       heat,
  output logic [9:0] target_temp,
  output logic [7:0] remaining,
  output logic [1:0] state,
  output logic       preheated,
  output logic       done
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    PREHEAT = 2'd1,
    BAKE    = 2'd2,
    DONE    = 2'd3
  } state_t;

  state_t     cur, nxt;
  logic       heat_n;
  logic [9:0] target_n;
  logic [7:0] rem_n;
  logic [9:0] clamped;
  logic [9:0] low;

  assign clamped = (setpoint > MAX_TEMP) ? MAX_TEMP : setpoint;

  // Lower edge of the hysteresis band, pinned at zero for tiny setpoints.
  assign low = (target_temp > HYST) ? (target_temp - HYST) : 10'd0;

  always_comb begin
    nxt      = cur;
    heat_n   = heat;
    target_n = target_temp;
    rem_n    = remaining;
    if (cancel) begin
      nxt    = IDLE;
      heat_n = 1'b0;
      rem_n  = 8'd0;
    end else begin
      unique case (cur)
        IDLE, DONE: begin
          heat_n = 1'b0;
          if (start) begin
            nxt      = PREHEAT;
            target_n = clamped;
            rem_n    = bake_time;
          end
        end
        PREHEAT: begin
          if (oven_temp >= target_temp) begin
            nxt    = BAKE;
            heat_n = 1'b0;
          end else begin
            heat_n = 1'b1;
          end
        end
        BAKE: begin
          if (remaining == 8'd0) begin
            nxt    = DONE;
            heat_n = 1'b0;
          end else begin
            if (oven_temp < low)
              heat_n = 1'b1;
            else if (oven_temp >= target_temp)
              heat_n = 1'b0;
            if (sec_tick) begin
              if (remaining == 8'd1) begin
                nxt    = DONE;
                heat_n = 1'b0;
                rem_n  = 8'd0;
              end else begin
                rem_n = remaining - 8'd1;
              end
            end
          end
        end
      endcase
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      cur         <= IDLE;
      heat        <= 1'b0;
      target_temp <= 10'd0;
      remaining   <= 8'd0;
      preheated   <= 1'b0;
      done        <= 1'b0;
    end else begin
      cur         <= nxt;
      heat        <= heat_n;
      target_temp <= target_n;
      remaining   <= rem_n;
      preheated   <= (nxt == BAKE);
      done        <= (nxt == DONE);
    end
  end

  assign state = cur;

endmodule

// File: tb/tb_oven_heat_controller.sv
// Bench for oven_heat_controller: scripted steps push hand-derived
// expectations to a scoreboard queue, popped and compared after each edge.
module tb_oven_heat_controller;

  logic       clock = 1'b0;
  logic       reset = 1'b0;
  logic       start = 1'b0;
  logic       cancel = 1'b0;
  logic       sec_tick = 1'b0;
  logic [9:0] setpoint = '0;
  logic [7:0] bake_time = '0;
  logic [9:0] oven_temp = '0;
  logic       heat;
  logic [9:0] target_temp;
  logic [7:0] remaining;
  logic [1:0] state;
  logic       preheated;
  logic       done;

  typedef struct packed {
    logic [1:0] s;
    logic       h;
    logic [9:0] t;
    logic [7:0] r;
  } exp_t;

  exp_t  sb_q[$];
  string tag_q[$];
  int    n_chk = 0;
  int    n_err = 0;

  oven_heat_controller dut (
    .clock       (clock),
    .reset       (reset),
    .start       (start),
    .cancel      (cancel),
    .sec_tick    (sec_tick),
    .setpoint    (setpoint),
    .bake_time   (bake_time),
    .oven_temp   (oven_temp),
    .heat        (heat),
    .target_temp (target_temp),
    .remaining   (remaining),
    .state       (state),
    .preheated   (preheated),
    .done        (done)
  );

  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [31:0] got,
                       input logic [31:0] want);
    n_chk++;
    if (got !== want) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d", tag, got, want);
    end
  endtask

  // One clock: drive inputs, queue expected outputs, compare after the edge.
  task automatic step(input string tag,
                      input logic rs, input logic st,
                      input logic cn, input logic tk,
                      input logic [9:0] sp, input logic [7:0] bt,
                      input logic [9:0] ot,
                      input logic [1:0] es, input logic eh,
                      input logic [9:0] et, input logic [7:0] er);
    exp_t  e;
    string t;
    @(negedge clock);
    reset     = rs;
    start     = st;
    cancel    = cn;
    sec_tick  = tk;
    setpoint  = sp;
    bake_time = bt;
    oven_temp = ot;
    sb_q.push_back('{s: es, h: eh, t: et, r: er});
    tag_q.push_back(tag);
    @(posedge clock);
    #1;
    if (sb_q.size() == 0) begin
      check({tag, "_sb_empty"}, 1, 0);
    end else begin
      e = sb_q.pop_front();
      t = tag_q.pop_front();
      check({t, "_state"}, state, e.s);
      check({t, "_heat"}, heat, e.h);
      check({t, "_target"}, target_temp, e.t);
      check({t, "_rem"}, remaining, e.r);
      check({t, "_preheated"}, preheated, e.s == 2'd2);
      check({t, "_done"}, done, e.s == 2'd3);
    end
  endtask

  initial begin
    //   tag          rs st cn tk  sp    bt   ot     s  h  t    r
    step("reset",     1, 0, 0, 0,    0,  0,    0,   0, 0,   0,  0);
    step("idle",      0, 0, 0, 1,    0,  0,    0,   0, 0,   0,  0);
    // normal run: 300 for 3 s
    step("a_start",   0, 1, 0, 0,  300,  3,    0,   1, 0, 300,  3);
    step("a_ph0",     0, 0, 0, 0,    0,  0,    0,   1, 1, 300,  3);
    step("a_ph150",   0, 0, 0, 1,    0,  0,  150,   1, 1, 300,  3);
    step("a_ph299",   0, 0, 0, 0,    0,  0,  299,   1, 1, 300,  3);
    step("a_tobake",  0, 0, 0, 1,    0,  0,  300,   2, 0, 300,  3);
    step("a_h297",    0, 0, 0, 0,    0,  0,  297,   2, 0, 300,  3);
    step("a_h295",    0, 0, 0, 0,    0,  0,  295,   2, 1, 300,  3);
    step("a_h298",    0, 0, 0, 0,    0,  0,  298,   2, 1, 300,  3);
    step("a_h300",    0, 0, 0, 0,    0,  0,  300,   2, 0, 300,  3);
    step("a_tick1",   0, 0, 0, 1,    0,  0,  300,   2, 0, 300,  2);
    step("a_tick2",   0, 0, 0, 1,    0,  0,  290,   2, 1, 300,  1);
    step("a_tick3",   0, 0, 0, 1,    0,  0,  290,   3, 0, 300,  0);
    step("a_donetk",  0, 0, 0, 1,    0,  0,  100,   3, 0, 300,  0);
    // restart from DONE, start ignored in PREHEAT, cancel beats start
    step("b_start",   0, 1, 0, 0,  150,  5,  100,   1, 0, 150,  5);
    step("b_ign",     0, 1, 0, 0,  400,  9,  100,   1, 1, 150,  5);
    step("b_tobake",  0, 0, 0, 0,    0,  0,  150,   2, 0, 150,  5);
    step("b_bkstart", 0, 1, 0, 0,  420,  7,  150,   2, 0, 150,  5);
    step("b_cnst",    0, 1, 1, 0,  250,  7,  150,   0, 0, 150,  0);
    step("b_idletk",  0, 0, 0, 1,    0,  0,  150,   0, 0, 150,  0);
    // clamp to ceiling
    step("c_start",   0, 1, 0, 0, 1000, 30,    0,   1, 0, 500, 30);
    step("c_ph",      0, 0, 0, 0,    0,  0,    0,   1, 1, 500, 30);
    step("c_cancel",  0, 0, 1, 0,    0,  0,    0,   0, 0, 500,  0);
    // reset mid-bake
    step("d_start",   0, 1, 0, 0,  200, 30,    0,   1, 0, 200, 30);
    step("d_tobake",  0, 0, 0, 0,    0,  0,  200,   2, 0, 200, 30);
    step("d_tick",    0, 0, 0, 1,    0,  0,  200,   2, 0, 200, 29);
    step("d_reset",   1, 1, 1, 1,  300,  5,    0,   0, 0,   0,  0);
    // tiny setpoint: low band saturates at zero
    step("e_start",   0, 1, 0, 0,    2, 10,    1,   1, 0,   2, 10);
    step("e_ph",      0, 0, 0, 0,    0,  0,    1,   1, 1,   2, 10);
    step("e_tobake",  0, 0, 0, 0,    0,  0,    2,   2, 0,   2, 10);
    step("e_t1",      0, 0, 0, 0,    0,  0,    1,   2, 0,   2, 10);
    step("e_t0",      0, 0, 0, 0,    0,  0,    0,   2, 0,   2, 10);
    step("e_cancel",  0, 0, 1, 0,    0,  0,    0,   0, 0,   2,  0);
    // zero setpoint and zero bake time
    step("f_start",   0, 1, 0, 0,    0,  0,    5,   1, 0,   0,  0);
    step("f_bake",    0, 0, 0, 0,    0,  0,    5,   2, 0,   0,  0);
    step("f_done",    0, 0, 0, 0,    0,  0,    5,   3, 0,   0,  0);
    step("f_hold",    0, 0, 0, 0,    0,  0,    5,   3, 0,   0,  0);
    check("sb_drained", sb_q.size(), 0);
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
